// File: rtl/mhd_stream_checker.sv
`default_nettype none
// ============================================================================
// Module : mhd_stream_checker
// Brief  : Streaming Hamming-distance monitor with run statistics (2-stage pipe)
// Rev    : 1.0  initial release
// ============================================================================
module mhd_stream_checker #(
  parameter int  WIDTH = 64,
  parameter int  MHD   = 16,
  parameter int  CNT_W = 32,
  localparam int HD_W  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  output logic [HD_W-1:0]  res_hd,
  output logic             res_err,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [HD_W-1:0]  max_hd,
  output logic             first_err_vld,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  function automatic logic [HD_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [HD_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + HD_W'(v[i]);
    return n;
  endfunction

  logic [1:0]       r_state, w_next;
  logic             w_accept, w_start_ok;
  logic             r_s1_vld;
  logic [WIDTH-1:0] r_s1_diff;
  logic [CNT_W-1:0] r_s1_idx, r_s2_idx;
  logic [HD_W-1:0]  w_s1_hd;
  logic             w_s1_err;
  logic             r_res_valid, r_res_err;
  logic [HD_W-1:0]  r_res_hd, r_max_hd;
  logic [CNT_W-1:0] r_vec_cnt, r_err_cnt, r_first_idx;
  logic             r_first_vld;

  assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_accept   = in_valid && in_ready;
  assign w_s1_hd    = popcount(r_s1_diff);
  assign w_s1_err   = 32'(w_s1_hd) > MHD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // DRAIN ends once stage 1 is empty: the last result is then in stage 2 and
  // lands in the statistics on the same edge that enters DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_accept && in_last) w_next = S_DRAIN;
      S_DRAIN: if (!r_s1_vld) w_next = S_DONE;
      S_DONE:  if (start) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == S_RUN);
    busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
    done     = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld    <= 1'b0;
      r_s1_diff   <= '0;
      r_s1_idx    <= '0;
      r_res_valid <= 1'b0;
      r_res_hd    <= '0;
      r_res_err   <= 1'b0;
      r_s2_idx    <= '0;
    end else begin
      r_s1_vld    <= w_accept;
      if (w_accept) begin
        r_s1_diff <= a ^ b;
        r_s1_idx  <= r_vec_cnt;
      end
      r_res_valid <= r_s1_vld;
      if (r_s1_vld) begin
        r_res_hd  <= w_s1_hd;
        r_res_err <= w_s1_err;
        r_s2_idx  <= r_s1_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec_cnt   <= '0;
      r_err_cnt   <= '0;
      r_max_hd    <= '0;
      r_first_vld <= 1'b0;
      r_first_idx <= '0;
    end else if (w_start_ok) begin
      r_vec_cnt   <= '0;
      r_err_cnt   <= '0;
      r_max_hd    <= '0;
      r_first_vld <= 1'b0;
      r_first_idx <= '0;
    end else begin
      if (w_accept && (r_vec_cnt != '1)) r_vec_cnt <= r_vec_cnt + CNT_W'(1);
      if (r_res_valid) begin
        if (r_res_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_W'(1);
        if (r_res_hd > r_max_hd) r_max_hd <= r_res_hd;
        if (r_res_err && !r_first_vld) begin
          r_first_vld <= 1'b1;
          r_first_idx <= r_s2_idx;
        end
      end
    end
  end

  assign res_valid     = r_res_valid;
  assign res_hd        = r_res_hd;
  assign res_err       = r_res_err;
  assign vec_cnt       = r_vec_cnt;
  assign err_cnt       = r_err_cnt;
  assign max_hd        = r_max_hd;
  assign first_err_vld = r_first_vld;
  assign first_err_idx = r_first_idx;

endmodule
`default_nettype wire

// File: tb/tb_mhd_stream_checker.sv
`default_nettype none
// ============================================================================
// Module : tb_mhd_stream_checker
// Brief  : Directed self-checking bench for mhd_stream_checker
// Rev    : 1.0  initial release
// ============================================================================
module tb_mhd_stream_checker;

  localparam int WIDTH = 64;
  localparam int MHD   = 16;
  localparam int CNT_W = 32;
  localparam int HD_W  = 7;

  logic             clk, rst_n, start, in_valid, in_ready, in_last;
  logic [WIDTH-1:0] a, b;
  logic             res_valid, res_err, busy, done, first_err_vld;
  logic [HD_W-1:0]  res_hd, max_hd;
  logic [CNT_W-1:0] vec_cnt, err_cnt, first_err_idx;

  mhd_stream_checker #(.WIDTH(WIDTH), .MHD(MHD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .a(a), .b(b),
    .res_valid(res_valid), .res_hd(res_hd), .res_err(res_err),
    .busy(busy), .done(done), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
    .max_hd(max_hd), .first_err_vld(first_err_vld), .first_err_idx(first_err_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // Expected-behaviour tracking: control state and a 2-deep result pipe
  bit exp_run, exp_busy, exp_done;
  int drain;
  bit p1v, p2v;
  int p1hd, p2hd;
  int m_cnt, m_err, m_max, m_fidx;
  bit m_fv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats(input int vc, input int ec, input int mx, input bit fv, input int fi);
    chk("vec_cnt", 64'(vec_cnt), 64'(vc));
    chk("err_cnt", 64'(err_cnt), 64'(ec));
    chk("max_hd", 64'(max_hd), 64'(mx));
    chk("first_err_vld", 64'(first_err_vld), 64'(fv));
    chk("first_err_idx", 64'(first_err_idx), 64'(fi));
  endtask

  task automatic model_clear();
    m_cnt = 0; m_err = 0; m_max = 0; m_fidx = 0; m_fv = 0;
  endtask

  // One clock: check outputs at the negedge, then apply this cycle's inputs
  task automatic drive(input bit st, input bit v, input logic [63:0] ia,
                       input logic [63:0] ib, input bit il);
    bit acc;
    int hd;
    if (drain > 0) begin
      drain--;
      if (drain == 0) begin exp_done = 1; exp_busy = 0; end
    end
    chk("in_ready", 64'(in_ready), 64'(exp_run));
    chk("busy", 64'(busy), 64'(exp_busy));
    chk("done", 64'(done), 64'(exp_done));
    chk("res_valid", 64'(res_valid), 64'(p2v));
    if (p2v) begin
      chk("res_hd", 64'(res_hd), 64'(p2hd));
      chk("res_err", 64'(res_err), 64'(p2hd > MHD));
    end
    hd  = $countones(ia ^ ib);
    acc = v && exp_run;
    p2v = p1v; p2hd = p1hd;
    p1v = acc; p1hd = hd;
    if (acc) begin
      if (hd > MHD) begin
        m_err++;
        if (!m_fv) begin m_fv = 1; m_fidx = m_cnt; end
      end
      if (hd > m_max) m_max = hd;
      m_cnt++;
      if (il) begin exp_run = 0; drain = 3; end
    end
    if (st && !exp_busy) begin
      exp_run = 1; exp_busy = 1; exp_done = 0;
      model_clear();
    end
    start = st; in_valid = v; a = ia; b = ib; in_last = il;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, '0, 0);
  endtask

  task automatic check_zero();
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst res_valid", 64'(res_valid), 64'd0);
    chk("rst res_hd", 64'(res_hd), 64'd0);
    chk("rst res_err", 64'(res_err), 64'd0);
    check_stats(0, 0, 0, 0, 0);
  endtask

  logic [63:0] ra, rb, ones;

  initial begin
    ones = '1;
    rst_n = 0; start = 0; in_valid = 0; in_last = 0; a = '0; b = '0;
    exp_run = 0; exp_busy = 0; exp_done = 0; drain = 0;
    p1v = 0; p2v = 0; p1hd = 0; p2hd = 0;
    model_clear();
    repeat (3) @(negedge clk);
    check_zero();
    rst_n = 1;

    // in_valid held while IDLE is ignored
    repeat (3) drive(0, 1, ones, '0, 1);
    check_stats(0, 0, 0, 0, 0);

    // Run 1: hd 0,16,17,1 -> only the 17 violates (index 2)
    drive(1, 0, '0, '0, 0);
    drive(0, 1, '0, 64'h0, 0);
    drive(0, 1, '0, 64'hFFFF, 0);
    drive(0, 1, '0, 64'h1FFFF, 0);
    drive(0, 1, '0, 64'h1, 1);
    idle(4);
    check_stats(4, 1, 17, 1, 2);

    // Start from DONE clears stats on the same edge; then hd 64 and 0
    drive(1, 0, '0, '0, 0);
    check_stats(0, 0, 0, 0, 0);
    drive(0, 1, ones, '0, 0);
    drive(0, 1, 64'hA5A5_0000_FFFF_1234, 64'hA5A5_0000_FFFF_1234, 1);
    idle(4);
    check_stats(2, 1, 64, 1, 0);

    // 100 back-to-back random beats
    drive(1, 0, '0, '0, 0);
    for (int i = 0; i < 100; i++) begin
      ra = {$urandom, $urandom};
      rb = ra ^ ({$urandom, $urandom} & {$urandom, $urandom});
      drive(0, 1, ra, rb, i == 99);
    end
    idle(4);
    check_stats(100, m_err, m_max, m_fv, m_fidx);

    // Gaps, start pulsed during RUN; hd 8, 18, 4
    drive(1, 0, '0, '0, 0);
    drive(0, 1, '0, 64'hFF, 0);
    drive(0, 0, ones, '0, 0);
    drive(1, 1, '0, 64'h3FFFF, 0);
    drive(0, 0, '0, '0, 0);
    drive(1, 0, '0, '0, 0);
    drive(0, 1, '0, 64'hF, 1);
    idle(4);
    check_stats(3, 1, 18, 1, 1);
    repeat (3) drive(0, 1, ones, '0, 1);
    check_stats(3, 1, 18, 1, 1);

    // Asynchronous reset mid-stream
    drive(1, 0, '0, '0, 0);
    repeat (3) drive(0, 1, '0, ones, 0);
    rst_n = 0;
    #1;
    check_zero();
    exp_run = 0; exp_busy = 0; exp_done = 0; drain = 0;
    p1v = 0; p2v = 0;
    model_clear();
    @(negedge clk);
    in_valid = 0; start = 0;
    rst_n = 1;
    drive(1, 0, '0, '0, 0);
    drive(0, 1, '0, 64'h7, 0);
    drive(0, 1, '0, 64'h1_FFFF_FFFF, 0);
    drive(0, 1, '0, 64'h3, 1);
    idle(4);
    check_stats(3, 1, 33, 1, 1);

    // Second run without violations; hd 16 sits exactly on the limit
    drive(1, 0, '0, '0, 0);
    check_stats(0, 0, 0, 0, 0);
    drive(0, 1, 64'h1234, 64'h1235, 0);
    drive(0, 1, 64'hFFFF_0000, 64'h0000_0000, 1);
    idle(4);
    check_stats(2, 0, 16, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
